// File: rtl/multdiv_unit.sv
// ---------------------------------------------------------------------------
// multdiv_unit
// Iterative signed multiply / divide unit for the execute stage. A one-cycle
// start pulse latches the operands; the operation then runs for WIDTH cycles
// (radix-2 Booth multiply or restoring divide on magnitudes) and the result
// is presented with a one-cycle ready strobe.
//
// Ports:
//   clock           system clock, rising edge
//   reset           synchronous active-low reset
//   ctrl_MULT       start pulse: signed multiply (wins over ctrl_DIV)
//   ctrl_DIV        start pulse: signed divide
//   data_operandA   multiplicand / dividend, sampled on the start edge
//   data_operandB   multiplier / divisor, sampled on the start edge
//   data_result     low WIDTH bits of product, or quotient
//   data_exception  multiply overflow, divide-by-zero or MIN/-1 overflow
//   data_resultRDY  one-cycle strobe: result and exception valid
//   busy            high from the cycle after the start edge through ready
// ---------------------------------------------------------------------------
module multdiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_MULT,
    input  logic             ctrl_DIV,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
    localparam logic [CW-1:0]    ONE_CNT  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] MIN_W    = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    // Two's-complement magnitude; MIN maps to 2^(WIDTH-1), which fits unsigned.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] x);
        if (x[WIDTH-1]) begin
            abs_val = ~x + ONE_W;
        end else begin
            abs_val = x;
        end
    endfunction

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    // Booth register: {acc[WIDTH:0], multiplier[WIDTH-1:0], q_-1}. The
    // accumulator carries one guard bit so that subtracting MIN cannot wrap.
    logic [2*WIDTH+1:0] prod_q;
    logic [WIDTH:0]     mcand_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvsr_q;
    logic               neg_q;
    logic               dz_q;
    logic               ovf_q;
    logic [WIDTH-1:0]   result_q;
    logic               exc_q;
    logic               rdy_q;
    logic               busy_q;

    logic [WIDTH:0]     acc_d;
    logic [2*WIDTH+1:0] prod_d;
    logic [WIDTH:0]     rem_shift_d;
    logic [WIDTH:0]     diff_d;
    logic [WIDTH-1:0]   rem_d;
    logic [WIDTH-1:0]   quo_d;
    logic [WIDTH-1:0]   mul_res_d;
    logic               mul_exc_d;
    logic [WIDTH-1:0]   div_res_d;
    logic               div_exc_d;

    assign data_result    = result_q;
    assign data_exception = exc_q;
    assign data_resultRDY = rdy_q;
    assign busy           = busy_q;

    // One Booth step and one restoring-division step, plus the final result
    // formatting used when the last step lands.
    always_comb begin
        acc_d       = prod_q[2*WIDTH+1:WIDTH+1];
        prod_d      = prod_q;
        rem_shift_d = {rem_q, quo_q[WIDTH-1]};
        diff_d      = rem_shift_d - {1'b0, dvsr_q};
        rem_d       = rem_q;
        quo_d       = quo_q;
        mul_res_d   = ZERO_W;
        mul_exc_d   = 1'b0;
        div_res_d   = ZERO_W;
        div_exc_d   = 1'b0;

        case (prod_q[1:0])
            2'b01:   acc_d = prod_q[2*WIDTH+1:WIDTH+1] + mcand_q;
            2'b10:   acc_d = prod_q[2*WIDTH+1:WIDTH+1] - mcand_q;
            default: acc_d = prod_q[2*WIDTH+1:WIDTH+1];
        endcase
        prod_d = {acc_d[WIDTH], acc_d, prod_q[WIDTH:1]};

        // Full signed product lives in prod_d[2*WIDTH:1]; overflow when bits
        // [2W-1:W-1] of it are neither all zeros nor all ones.
        mul_res_d = prod_d[WIDTH:1];
        if ((prod_d[2*WIDTH:WIDTH] != {(WIDTH+1){1'b0}}) &&
            (prod_d[2*WIDTH:WIDTH] != {(WIDTH+1){1'b1}})) begin
            mul_exc_d = 1'b1;
        end else begin
            mul_exc_d = 1'b0;
        end

        if (!diff_d[WIDTH]) begin
            rem_d = diff_d[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_d = rem_shift_d[WIDTH-1:0];
            quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end

        // MIN / -1 needs no special value: magnitude quotient is 2^(W-1)
        // with positive sign, which already reads back as MIN.
        if (dz_q) begin
            div_res_d = ZERO_W;
        end else if (neg_q) begin
            div_res_d = ~quo_d + ONE_W;
        end else begin
            div_res_d = quo_d;
        end
        div_exc_d = dz_q | ovf_q;
    end

    // Control FSM with registered outputs; a start pulse in any state
    // restarts the unit with freshly latched operands.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= {CW{1'b0}};
            prod_q   <= {(2*WIDTH+2){1'b0}};
            mcand_q  <= {(WIDTH+1){1'b0}};
            rem_q    <= ZERO_W;
            quo_q    <= ZERO_W;
            dvsr_q   <= ZERO_W;
            neg_q    <= 1'b0;
            dz_q     <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= ZERO_W;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
            busy_q   <= 1'b0;
        end else if (ctrl_MULT || ctrl_DIV) begin
            state_q <= ctrl_MULT ? S_MUL : S_DIV;
            cnt_q   <= {CW{1'b0}};
            prod_q  <= {{(WIDTH+1){1'b0}}, data_operandB, 1'b0};
            mcand_q <= {data_operandA[WIDTH-1], data_operandA};
            rem_q   <= ZERO_W;
            quo_q   <= abs_val(data_operandA);
            dvsr_q  <= abs_val(data_operandB);
            neg_q   <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            dz_q    <= (data_operandB == ZERO_W);
            ovf_q   <= (data_operandA == MIN_W) && (data_operandB == ONES_W);
            rdy_q   <= 1'b0;
            busy_q  <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    rdy_q  <= 1'b0;
                    busy_q <= 1'b0;
                end
                S_MUL: begin
                    prod_q <= prod_d;
                    cnt_q  <= cnt_q + ONE_CNT;
                    if (cnt_q == LAST_CNT) begin
                        state_q  <= S_DONE;
                        result_q <= mul_res_d;
                        exc_q    <= mul_exc_d;
                        rdy_q    <= 1'b1;
                    end else begin
                        state_q <= S_MUL;
                    end
                end
                S_DIV: begin
                    rem_q <= rem_d;
                    quo_q <= quo_d;
                    cnt_q <= cnt_q + ONE_CNT;
                    if (cnt_q == LAST_CNT) begin
                        state_q  <= S_DONE;
                        result_q <= div_res_d;
                        exc_q    <= div_exc_d;
                        rdy_q    <= 1'b1;
                    end else begin
                        state_q <= S_DIV;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= S_IDLE;
                    rdy_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// ---------------------------------------------------------------------------
// tb_multdiv_unit
// Self-checking bench for multdiv_unit: directed cases plus randomized
// multiply/divide operations compared against an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_multdiv_unit;

    localparam int W = 32;

    logic         clock;
    logic         reset;
    logic         ctrl_MULT;
    logic         ctrl_DIV;
    logic [W-1:0] data_operandA;
    logic [W-1:0] data_operandB;
    logic [W-1:0] data_result;
    logic         data_exception;
    logic         data_resultRDY;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    multdiv_unit #(.WIDTH(W)) dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (data_operandA),
        .data_operandB  (data_operandB),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    // Free-running clock, 10 time units per period.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Reference: exact signed arithmetic on 64-bit integers.
    function automatic void ref_model(input bit is_mul, input logic [31:0] a, input logic [31:0] b,
                                      output logic [31:0] r, output logic e);
        longint sa;
        longint sb;
        longint p;
        longint lo_ext;
        logic [63:0] pv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (is_mul) begin
            p      = sa * sb;
            pv     = p;
            r      = pv[31:0];
            lo_ext = longint'($signed(pv[31:0]));
            e      = (p != lo_ext);
        end else if (b == 32'h0000_0000) begin
            r = 32'h0000_0000;
            e = 1'b1;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            r = 32'h8000_0000;
            e = 1'b1;
        end else begin
            p  = sa / sb;
            pv = p;
            r  = pv[31:0];
            e  = 1'b0;
        end
    endfunction

    // Present a start pulse for one edge, then scramble the operands.
    task automatic start_op(input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT     = m;
        ctrl_DIV      = d;
        data_operandA = a;
        data_operandB = b;
        @(posedge clock);
        #1;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = $urandom;
        data_operandB = $urandom;
    endtask

    // Follow an operation from just after its start edge to one cycle past ready.
    task automatic observe_op(input string tag, input logic [31:0] er, input logic ee);
        int first_rdy = -1;
        int rdy_cnt   = 0;
        int busy_bad  = 0;
        logic [31:0] got_r = 32'h0;
        logic        got_e = 1'b0;
        if (busy !== 1'b1) busy_bad++;
        for (int k = 1; k <= W + 1; k++) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) begin
                rdy_cnt++;
                if (first_rdy < 0) begin
                    first_rdy = k;
                    got_r     = data_result;
                    got_e     = data_exception;
                end
            end
            if (k <= W && busy !== 1'b1) busy_bad++;
            if (k == W + 1 && busy !== 1'b0) busy_bad++;
        end
        check_value({tag, ".latency"}, 32'(first_rdy), 32'(W));
        check_value({tag, ".rdy_count"}, 32'(rdy_cnt), 32'd1);
        check_value({tag, ".busy"}, 32'(busy_bad), 32'd0);
        check_value({tag, ".result"}, got_r, er);
        check_value({tag, ".exception"}, {31'd0, got_e}, {31'd0, ee});
        check_value({tag, ".hold"}, data_result, er);
    endtask

    task automatic run_op(input string tag, input bit m, input bit d, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        ee;
        ref_model(m, a, b, er, ee);
        start_op(m, d, a, b);
        observe_op(tag, er, ee);
    endtask

    function automatic logic [31:0] pick_operand();
        logic [31:0] specials [5];
        specials[0] = 32'h0000_0000;
        specials[1] = 32'h0000_0001;
        specials[2] = 32'hFFFF_FFFF;
        specials[3] = 32'h8000_0000;
        specials[4] = 32'h7FFF_FFFF;
        case ($urandom_range(0, 3))
            0:       return specials[$urandom_range(0, 4)];
            1:       return 32'($signed($urandom_range(0, 200)) - 100);
            2:       return 32'($urandom_range(0, 65535));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int rdy_seen;
        logic [31:0] er;
        logic        ee;

        reset         = 1'b0;
        ctrl_MULT     = 1'b0;
        ctrl_DIV      = 1'b0;
        data_operandA = 32'h0;
        data_operandB = 32'h0;
        repeat (2) @(posedge clock);
        #1;
        check_value("reset.result", data_result, 32'h0);
        check_value("reset.exception", {31'd0, data_exception}, 32'd0);
        check_value("reset.rdy", {31'd0, data_resultRDY}, 32'd0);
        check_value("reset.busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        check_value("idle.busy", {31'd0, busy}, 32'd0);

        // Directed cases with hand-derived expectations.
        start_op(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFD);
        observe_op("mul_7x-3", 32'hFFFF_FFEB, 1'b0);
        start_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        observe_op("mul_ovf", 32'h0000_0000, 1'b1);
        start_op(1'b1, 1'b0, 32'h7FFF_FFFF, 32'd1);
        observe_op("mul_max", 32'h7FFF_FFFF, 1'b0);
        start_op(1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
        observe_op("mul_min", 32'h8000_0000, 1'b1);
        start_op(1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2);
        observe_op("div_-7/2", 32'hFFFF_FFFD, 1'b0);
        start_op(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
        observe_op("div_100/-7", 32'hFFFF_FFF2, 1'b0);
        start_op(1'b0, 1'b1, 32'd5, 32'd0);
        observe_op("div_by0", 32'h0000_0000, 1'b1);
        start_op(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        observe_op("div_min", 32'h8000_0000, 1'b1);
        start_op(1'b1, 1'b1, 32'd6, 32'd3);
        observe_op("both", 32'd18, 1'b0);

        // Abort: divide restarts a running multiply; no strobe in between.
        start_op(1'b1, 1'b0, 32'd5, 32'd6);
        rdy_seen = 0;
        repeat (9) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        start_op(1'b0, 1'b1, 32'd20, 32'd4);
        check_value("abort.early_rdy", 32'(rdy_seen), 32'd0);
        observe_op("abort", 32'd5, 1'b0);

        // Restart issued on the edge that leaves the ready cycle.
        start_op(1'b1, 1'b0, 32'd2, 32'd3);
        rdy_seen = 0;
        repeat (W) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1) rdy_seen++;
        end
        check_value("done_abort.first_rdy", 32'(rdy_seen), 32'd1);
        check_value("done_abort.first_res", data_result, 32'd6);
        start_op(1'b1, 1'b0, 32'hFFFF_FFFE, 32'd9);
        observe_op("done_abort", 32'hFFFF_FFEE, 1'b0);

        // Reset in the middle of a multiply.
        start_op(1'b1, 1'b0, 32'd11, 32'd13);
        repeat (14) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        check_value("midreset.result", data_result, 32'h0);
        check_value("midreset.exception", {31'd0, data_exception}, 32'd0);
        check_value("midreset.rdy", {31'd0, data_resultRDY}, 32'd0);
        check_value("midreset.busy", {31'd0, busy}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        rdy_seen = 0;
        repeat (40) begin
            @(posedge clock);
            #1;
            if (data_resultRDY === 1'b1 || busy === 1'b1) rdy_seen++;
        end
        check_value("midreset.no_rdy", 32'(rdy_seen), 32'd0);
        start_op(1'b1, 1'b0, 32'd3, 32'd4);
        observe_op("after_reset", 32'd12, 1'b0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            bit          m;
            a = pick_operand();
            b = pick_operand();
            m = bit'($urandom_range(0, 1));
            ref_model(m, a, b, er, ee);
            start_op(m, ~m, a, b);
            observe_op(m ? "rnd_mul" : "rnd_div", er, ee);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed multiply/divide responder for the pipelined processor's execute stage.
- Accepts a one-cycle start pulse when decode identifies mul (opcode 00000, ALU_op 00110) or div (opcode 00000, ALU_op 00111).
- Computes over a fixed number of cycles. `busy` stalls the pipeline while it runs.
- Returns the result with a one-cycle ready strobe and an exception flag. The exception flag makes the writeback stage write status register $r30.

Parameters:
- WIDTH, 32, operand and result width in bits. Iteration count equals WIDTH.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-low reset (sampled on the rising edge of clock).
- ctrl_MULT  input  1  one-cycle pulse: start a signed multiply of the current operands.
- ctrl_DIV  input  1  one-cycle pulse: start a signed divide of the current operands.
- data_operandA  input  WIDTH  multiplicand / dividend; sampled only on the start edge.
- data_operandB  input  WIDTH  multiplier / divisor; sampled only on the start edge.
- data_result  output  WIDTH  low WIDTH bits of the product, or the quotient.
- data_exception  output  1  overflow or divide-by-zero; qualified by data_resultRDY.
- data_resultRDY  output  1  high for exactly one cycle when result and exception are valid.
- busy  output  1  high from the cycle after the start edge through the ready cycle, inclusive.

Behaviour:
- Reset (reset==0 at an edge):
  - state=IDLE, counter=0, internal registers cleared.
  - data_result=0, data_exception=0, data_resultRDY=0, busy=0.
  - Reset mid-operation abandons the operation; no ready strobe follows.
- States and transitions:
  - IDLE → MUL on ctrl_MULT. IDLE → DIV on ctrl_DIV.
  - MUL/DIV → DONE after WIDTH iterations.
  - DONE → IDLE unconditionally.
- Start edge E0:
  - Operands are latched, counter=0, op type recorded.
  - If ctrl_MULT and ctrl_DIV are both high, multiply wins.
- Iterations:
  - One iteration per edge, E1..E(WIDTH).
  - At E(WIDTH) the state moves to DONE, and data_result, data_exception and data_resultRDY=1 are registered.
  - data_resultRDY is therefore high for the cycle between E(WIDTH) and E(WIDTH+1): latency is WIDTH cycles (32) after the start edge.
  - resultRDY deasserts at E(WIDTH+1), when the state returns to IDLE.
- Between operations, data_result and data_exception hold their last values until the next start edge.
- A start pulse seen at any edge while busy (including the DONE cycle) aborts the current operation:
  - Operands are relatched and the counter restarts.
  - No ready strobe is issued for the aborted operation.
- Multiply:
  - Radix-2 Booth over a 2*WIDTH+1-bit product register.
  - data_result = product[WIDTH-1:0].
  - data_exception=1 iff product[2*WIDTH-1:WIDTH-1] is not all-0 and not all-1, i.e. the full product does not sign-fit in WIDTH bits.
- Divide:
  - Signed. The unsigned non-restoring or restoring core operates on magnitudes.
  - Quotient sign = signA XOR signB; truncation toward zero; remainder discarded.
  - divisor==0: data_result=0, data_exception=1. The full WIDTH-cycle latency is still observed.
  - A=-2^(WIDTH-1), B=-1: data_result=0x80000000, data_exception=1.
  - All other cases: data_exception=0.
- Start pulses in IDLE with operands changing after E0 have no effect on the running operation.
- busy=1 from the cycle after E0 through the DONE cycle inclusive; 0 in IDLE.

Test Plan:
- Reset held low 2 cycles, then released: all outputs 0, busy=0. Pulse ctrl_MULT with A=7, B=-3: exactly 32 cycles later resultRDY=1 for 1 cycle, result=0xFFFFFFEB (-21), exception=0.
- MULT A=0x00010000, B=0x00010000 → result=0x00000000, exception=1. MULT A=0x7FFFFFFF, B=1 → 0x7FFFFFFF, exception=0. MULT A=0x80000000, B=-1 → exception=1.
- DIV A=-7, B=2 → result=0xFFFFFFFD (-3), exception=0. DIV A=100, B=-7 → -14. DIV A=5, B=0 → result=0, exception=1, still 32-cycle latency.
- DIV A=0x80000000, B=0xFFFFFFFF → result=0x80000000, exception=1.
- Start MULT 5*6, then pulse ctrl_DIV 20/4 at cycle 10 → no strobe at the original slot; a single strobe 32 cycles after the second start with result=5. Simultaneous ctrl_MULT and ctrl_DIV with A=6, B=3 → result=18.
- Drive reset low at cycle 15 of a multiply → outputs 0 next cycle, no resultRDY ever appears. A new MULT 3*4 afterwards → result=12 at the normal latency.
